// File: rtl/draw_source_arbiter.sv
// Per-frame arbiter: grants the shared draw bus to enabled sources in ascending order and streams accepted pixels to the framebuffer.
// One register stage from bus to fb write port; write_awaited is the only backpressure, 1 pixel/cycle while granted.
module draw_source_arbiter #(
    parameter int NUM_SOURCES      = 4,
    parameter int SOURCE_SEL_ADDRW = 2,
    parameter int COLOR_DEPTH      = 9,
    parameter int FB_WIDTH         = 640,
    parameter int FB_HEIGHT        = 480,
    parameter int WAIT_TIMEOUT     = 4095,
    parameter int MAX_BURST        = 4096
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        frame,
    input  logic [NUM_SOURCES-1:0]      source_enable,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    input  logic                        write_active,
    input  logic [COLOR_DEPTH-1:0]      write_color_data,
    input  logic                        write_transparent,
    input  logic [31:0]                 write_x_addr,
    input  logic [31:0]                 write_y_addr,
    output logic                        fb_we,
    output logic [18:0]                 fb_addr,
    output logic [COLOR_DEPTH-1:0]      fb_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic [7:0]                  overrun_count
);

    localparam int PTR_W   = SOURCE_SEL_ADDRW + 1;
    localparam int WAIT_W  = $clog2(WAIT_TIMEOUT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int ADDR_W  = 19;

    localparam logic signed [31:0] FB_W_S = FB_WIDTH;
    localparam logic signed [31:0] FB_H_S = FB_HEIGHT;
    localparam logic [ADDR_W-1:0]  FB_W_A = ADDR_W'(FB_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_GRANT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_SOURCES-1:0]      en_q, en_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
    logic [WAIT_W-1:0]           wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]          burst_cnt_q, burst_cnt_d;
    logic                        fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]           fb_addr_q, fb_addr_d;
    logic [COLOR_DEPTH-1:0]      fb_data_q, fb_data_d;
    logic [7:0]                  overrun_q, overrun_d;

    logic                        bus_owned;
    logic                        bus_act;
    logic                        pix_ok;
    logic                        scan_found;
    logic [PTR_W-1:0]            scan_idx;
    logic                        wait_last;
    logic                        burst_last;
    logic signed [31:0]          x_s;
    logic signed [31:0]          y_s;
    logic [ADDR_W-1:0]           pix_addr;

    assign x_s        = write_x_addr;
    assign y_s        = write_y_addr;
    assign pix_addr   = write_y_addr[ADDR_W-1:0] * FB_W_A + write_x_addr[ADDR_W-1:0];
    assign bus_owned  = (state_q == S_GRANT) || (state_q == S_STREAM);
    assign wait_last  = (wait_cnt_q == WAIT_W'(WAIT_TIMEOUT - 1));
    assign burst_last = (burst_cnt_q == BURST_W'(MAX_BURST - 1));

    // Undriven or unknown bus levels fall into the else branch and read as idle / opaque-reject.
    always_comb begin
        bus_act = 1'b0;
        if (bus_owned && (write_active == 1'b1)) begin
            bus_act = 1'b1;
        end
        pix_ok = 1'b0;
        if ((write_transparent == 1'b0) &&
            (x_s >= 32'sd0) && (x_s < FB_W_S) &&
            (y_s >= 32'sd0) && (y_s < FB_H_S)) begin
            pix_ok = 1'b1;
        end
    end

    // Lowest enabled source at or above the pointer; iterate downward so the lowest index wins.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (en_q[i] && (PTR_W'(i) >= ptr_q)) begin
                scan_found = 1'b1;
                scan_idx   = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                state_d = scan_found ? S_GRANT : S_DONE;
            end
            S_GRANT: begin
                if (bus_act) begin
                    state_d = burst_last ? S_SCAN : S_STREAM;
                end else if (wait_last) begin
                    state_d = S_SCAN;
                end
            end
            S_STREAM: begin
                if (!bus_act || burst_last) begin
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        write_awaited = 1'b0;
        busy          = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            S_SCAN:   busy = 1'b1;
            S_GRANT,
            S_STREAM: begin
                busy          = 1'b1;
                write_awaited = 1'b1;
            end
            S_DONE:   frame_done = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        en_d        = en_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        overrun_d   = overrun_q;

        if ((state_q == S_IDLE) && frame) begin
            en_d  = source_enable;
            ptr_d = '0;
        end

        if (state_q == S_SCAN) begin
            wait_cnt_d  = '0;
            burst_cnt_d = '0;
            if (scan_found) begin
                ptr_d = scan_idx;
                sel_d = scan_idx[SOURCE_SEL_ADDRW-1:0];
            end
        end

        if ((state_q == S_GRANT) && !bus_act) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        if (bus_act) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
            if (pix_ok) begin
                fb_we_d   = 1'b1;
                fb_addr_d = pix_addr;
                fb_data_d = write_color_data;
            end
        end

        // Leaving the bus, by release, timeout or burst cap, moves on past the current source.
        if (bus_owned && (state_d == S_SCAN)) begin
            ptr_d = ptr_q + PTR_W'(1);
        end

        if (frame && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            en_q        <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            overrun_q   <= '0;
        end else begin
            en_q        <= en_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign write_source_sel = sel_q;
    assign fb_we            = fb_we_q;
    assign fb_addr          = fb_addr_q;
    assign fb_data          = fb_data_q;
    assign overrun_count    = overrun_q;

endmodule
